// File: rtl/vga_text_pkg.sv
// Shared constants, stage bundles and prompt text for the
// text-mode VGA render pipeline.
package vga_text_pkg;

   localparam int PROMPT_MAX = 16;
   localparam int TEXT_AW    = 12;
   localparam int FONT_AW    = 12;
   localparam int LATENCY    = 4;

   localparam logic [7:0] PROMPT [PROMPT_MAX] = '{
      8'h53, 8'h53, 8'h73, 8'h68, 8'h65, 8'h6C, 8'h6C, 8'h24,
      8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20
   };

   typedef struct packed {
      logic [9:0] col;
      logic [9:0] row;
      logic [3:0] xo;
      logic [4:0] yo;
      logic       in_area;
   } cell_t;

   typedef struct packed {
      logic [3:0] xo;
      logic       in_area;
      logic       hit;
   } pix_t;

   function automatic logic [7:0] prompt_char(input logic [9:0] idx);
      if (idx < 10'(PROMPT_MAX)) return PROMPT[idx[3:0]];
      return 8'h20;
   endfunction

endpackage

// File: rtl/vga_text_mem_if.sv
// Read bus towards the external text RAM and font ROM.
// Both memories return data one clock after the address.
interface vga_text_mem_if #(
   parameter int CHAR_W = 9
);
   logic [11:0]       text_addr;
   logic [7:0]        text_data;
   logic [11:0]       font_addr;
   logic [CHAR_W-1:0] font_row;

   modport master (
      output text_addr,
      output font_addr,
      input  text_data,
      input  font_row
   );

   modport slave (
      input  text_addr,
      input  font_addr,
      output text_data,
      output font_row
   );
endinterface

// File: rtl/vga_cell_locator.sv
// Splits a pixel coordinate into character cell and
// in-glyph offset; exposes the unregistered cell too.
module vga_cell_locator
   import vga_text_pkg::*;
#(
   parameter int CHAR_W = 9,
   parameter int CHAR_H = 16,
   parameter int COLS   = 70,
   parameter int ROWS   = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] h_addr,
   input  logic [9:0] v_addr,
   input  logic       de_in,
   output logic [9:0] col_now,
   output logic [9:0] row_now,
   output logic       in_now,
   output cell_t      cell_q
);

   cell_t cell_d;

   // constant divide/modulo of the scan position
   always_comb begin
      cell_d         = '0;
      cell_d.col     = 10'(int'(h_addr) / CHAR_W);
      cell_d.xo      = 4'(int'(h_addr) % CHAR_W);
      cell_d.row     = 10'(int'(v_addr) / CHAR_H);
      cell_d.yo      = 5'(int'(v_addr) % CHAR_H);
      cell_d.in_area = (int'(cell_d.col) < COLS) &&
                       (int'(cell_d.row) < ROWS) && de_in;
      col_now        = cell_d.col;
      row_now        = cell_d.row;
      in_now         = cell_d.in_area;
   end

   // cell register, cleared by reset
   always_ff @(posedge clk) begin
      if (rst) cell_q <= '0;
      else     cell_q <= cell_d;
   end

endmodule

// File: rtl/vga_text_pipeline.sv
// Text-mode render pipeline: cell lookup, scrolled text fetch,
// prompt overlay, glyph fetch, blinking cursor, aligned syncs.
module vga_text_pipeline
   import vga_text_pkg::*;
#(
   parameter int CHAR_W       = 9,
   parameter int CHAR_H       = 16,
   parameter int COLS         = 70,
   parameter int ROWS         = 30,
   parameter int PROMPT_LEN   = 9,
   parameter int BLINK_FRAMES = 30
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [9:0]     h_addr,
   input  logic [9:0]     v_addr,
   input  logic           de_in,
   input  logic           hs_in,
   input  logic           vs_in,
   vga_text_mem_if.master mem,
   input  logic [7:0]     cursor_col,
   input  logic [7:0]     cursor_row,
   input  logic           cursor_en,
   input  logic           prompt_en,
   input  logic           scroll_req,
   input  logic           clear_scroll,
   output logic           pixel_on,
   output logic           de_out,
   output logic           hs_out,
   output logic           vs_out
);

   logic [9:0]         col_now;
   logic [9:0]         row_now;
   logic               in_now;
   cell_t              s1_q;
   cell_t              s2_q, s2_d;
   pix_t               s3_q, s3_d;
   pix_t               s4_q, s4_d;
   logic [TEXT_AW-1:0] text_addr_q, text_addr_d;
   logic [FONT_AW-1:0] font_addr_q, font_addr_d;
   logic               pixel_q, pixel_d;
   logic [LATENCY:0][2:0] sync_q, sync_d;
   logic [TEXT_AW-1:0] base_q, base_d;
   logic               pend_q, pend_d;
   logic [15:0]        fcnt_q, fcnt_d;
   logic               blink_q, blink_d;
   logic               vs_prev_q, vs_prev_d;
   logic               frame_start;
   logic [12:0]        vrow;
   logic [7:0]         ch;
   logic [CHAR_W-1:0]  glyph;

   vga_cell_locator #(
      .CHAR_W (CHAR_W),
      .CHAR_H (CHAR_H),
      .COLS   (COLS),
      .ROWS   (ROWS)
   ) u_loc (
      .clk     (clk),
      .rst     (rst),
      .h_addr  (h_addr),
      .v_addr  (v_addr),
      .de_in   (de_in),
      .col_now (col_now),
      .row_now (row_now),
      .in_now  (in_now),
      .cell_q  (s1_q)
   );

   assign frame_start = vs_in & ~vs_prev_q;

   // text RAM address with the scroll base as ring-buffer origin
   always_comb begin
      vrow = 13'(row_now) + 13'(base_q);
      if (int'(vrow) >= ROWS) vrow = vrow - 13'(ROWS);
      text_addr_d = '0;
      if (in_now)
         text_addr_d = TEXT_AW'(int'(vrow) * COLS + int'(col_now));
   end

   // hold the cell while the text RAM read is in flight
   always_comb s2_d = s1_q;

   // prompt overlay, glyph row address and cursor match
   always_comb begin
      ch = mem.text_data;
      if (prompt_en && (s2_q.row == {2'b00, cursor_row}) &&
          (int'(s2_q.col) < PROMPT_LEN))
         ch = prompt_char(s2_q.col);
      font_addr_d = FONT_AW'(int'(ch) * CHAR_H + int'(s2_q.yo));
      s3_d         = '0;
      s3_d.xo      = s2_q.xo;
      s3_d.in_area = s2_q.in_area;
      s3_d.hit     = cursor_en && blink_q &&
                     (s2_q.col == {2'b00, cursor_col}) &&
                     (s2_q.row == {2'b00, cursor_row}) &&
                     (int'(cursor_col) < COLS) &&
                     (int'(cursor_row) < ROWS);
   end

   // hold pixel context while the font ROM read is in flight
   always_comb s4_d = s3_q;

   // pick the glyph bit under xo and apply cursor inversion
   always_comb begin
      glyph   = mem.font_row << s4_q.xo;
      pixel_d = s4_q.in_area & (glyph[CHAR_W-1] ^ s4_q.hit);
   end

   // sync delay line matching the pixel path depth
   always_comb begin
      sync_d    = {sync_q[LATENCY-1:0], de_in, hs_in, vs_in};
      vs_prev_d = vs_in;
   end

   // scroll base, pending request and cursor blink timing
   always_comb begin
      base_d  = base_q;
      pend_d  = pend_q;
      fcnt_d  = fcnt_q;
      blink_d = blink_q;
      if (clear_scroll) begin
         base_d = '0;
         pend_d = 1'b0;
      end else if (frame_start && pend_q) begin
         base_d = (int'(base_q) == ROWS - 1) ? '0 : base_q + 12'd1;
         pend_d = scroll_req;
      end else if (scroll_req) begin
         pend_d = 1'b1;
      end
      if (frame_start) begin
         if (int'(fcnt_q) >= BLINK_FRAMES - 1) begin
            fcnt_d  = '0;
            blink_d = ~blink_q;
         end else begin
            fcnt_d = fcnt_q + 16'd1;
         end
      end
   end

   // pipeline and control state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_q        <= '0;
         s3_q        <= '0;
         s4_q        <= '0;
         text_addr_q <= '0;
         font_addr_q <= '0;
         pixel_q     <= 1'b0;
         sync_q      <= '0;
         base_q      <= '0;
         pend_q      <= 1'b0;
         fcnt_q      <= '0;
         blink_q     <= 1'b1;
         vs_prev_q   <= 1'b0;
      end else begin
         s2_q        <= s2_d;
         s3_q        <= s3_d;
         s4_q        <= s4_d;
         text_addr_q <= text_addr_d;
         font_addr_q <= font_addr_d;
         pixel_q     <= pixel_d;
         sync_q      <= sync_d;
         base_q      <= base_d;
         pend_q      <= pend_d;
         fcnt_q      <= fcnt_d;
         blink_q     <= blink_d;
         vs_prev_q   <= vs_prev_d;
      end
   end

   assign mem.text_addr = text_addr_q;
   assign mem.font_addr = font_addr_q;
   assign pixel_on      = pixel_q;
   assign de_out        = sync_q[LATENCY][2];
   assign hs_out        = sync_q[LATENCY][1];
   assign vs_out        = sync_q[LATENCY][0];

endmodule

// File: tb/tb_vga_text_pipeline.sv
// Bench for vga_text_pipeline: directed scenarios plus random
// frames, all checked against a cycle-indexed reference model.
module tb_vga_text_pipeline;

   localparam int CW = 9;
   localparam int CH = 16;
   localparam int NC = 70;
   localparam int NR = 30;
   localparam int PL = 9;
   localparam int BF = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] h_addr = '0;
   logic [9:0] v_addr = '0;
   logic       de_in = 1'b0;
   logic       hs_in = 1'b0;
   logic       vs_in = 1'b0;
   logic [7:0] cursor_col = '0;
   logic [7:0] cursor_row = '0;
   logic       cursor_en = 1'b0;
   logic       prompt_en = 1'b0;
   logic       scroll_req = 1'b0;
   logic       clear_scroll = 1'b0;
   logic       pixel_on, de_out, hs_out, vs_out;

   vga_text_mem_if #(.CHAR_W(CW)) mem ();

   vga_text_pipeline #(
      .CHAR_W       (CW),
      .CHAR_H       (CH),
      .COLS         (NC),
      .ROWS         (NR),
      .PROMPT_LEN   (PL),
      .BLINK_FRAMES (BF)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .h_addr       (h_addr),
      .v_addr       (v_addr),
      .de_in        (de_in),
      .hs_in        (hs_in),
      .vs_in        (vs_in),
      .mem          (mem),
      .cursor_col   (cursor_col),
      .cursor_row   (cursor_row),
      .cursor_en    (cursor_en),
      .prompt_en    (prompt_en),
      .scroll_req   (scroll_req),
      .clear_scroll (clear_scroll),
      .pixel_on     (pixel_on),
      .de_out       (de_out),
      .hs_out       (hs_out),
      .vs_out       (vs_out)
   );

   always #5 clk = ~clk;

   logic [7:0] tmem [4096];
   logic [8:0] fontm [4096];

   always @(posedge clk) begin
      mem.text_data <= tmem[mem.text_addr];
      mem.font_row  <= fontm[mem.font_addr];
   end

   string prompt_str = "SSshell$ ";

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int last_rst = 0;

   int   m_base = 0;
   logic m_pend = 1'b0;
   int   m_fcnt = 0;
   logic m_blink = 1'b1;
   logic m_vsp = 1'b0;

   int       e_ta [8];
   int       e_fa [8];
   logic     e_fachk [8];
   logic     e_pix [8];
   logic [2:0] e_sync [8];

   task automatic step(input int h, input int v, input logic d,
                       input logic hs, input logic vs,
                       input logic sr, input logic cl, input logic r);
      int col, row, xo, yo, ta, fa, sl, s;
      logic ia, hit, fs, ep;
      logic [7:0] ch;
      logic [8:0] g;
      logic [2:0] es;
      @(negedge clk);
      rst = r; h_addr = 10'(h); v_addr = 10'(v);
      de_in = d; hs_in = hs; vs_in = vs;
      scroll_req = sr; clear_scroll = cl;
      col = h / CW; xo = h % CW; row = v / CH; yo = v % CH;
      ia = d && (col < NC) && (row < NR);
      sl = cyc % 8;
      if (r) begin
         e_ta[sl] = 0; e_fachk[sl] = 1'b0;
         e_pix[sl] = 1'b0; e_sync[sl] = 3'b000;
         last_rst = cyc;
         m_base = 0; m_pend = 1'b0; m_fcnt = 0;
         m_blink = 1'b1; m_vsp = 1'b0;
      end else begin
         ta = ia ? ((row + m_base) % NR) * NC + col : 0;
         if (prompt_en && row == int'(cursor_row) && col < PL)
            ch = prompt_str[col];
         else
            ch = tmem[ta];
         fa = (int'(ch) * CH + yo) % 4096;
         hit = cursor_en && m_blink && col == int'(cursor_col) &&
               row == int'(cursor_row);
         g = fontm[fa];
         e_ta[sl] = ta; e_fa[sl] = fa; e_fachk[sl] = ia;
         e_pix[sl] = ia && (g[CW-1-xo] ^ hit);
         e_sync[sl] = {d, hs, vs};
         fs = vs && !m_vsp;
         m_vsp = vs;
         if (cl) begin
            m_base = 0; m_pend = 1'b0;
         end else if (fs && m_pend) begin
            m_base = (m_base + 1) % NR; m_pend = sr;
         end else if (sr) begin
            m_pend = 1'b1;
         end
         if (fs) begin
            m_fcnt++;
            if (m_fcnt == BF) begin
               m_fcnt = 0; m_blink = !m_blink;
            end
         end
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (mem.text_addr !== 12'(e_ta[sl])) begin
         n_err++;
         $display("FAIL text_addr cyc %0d got %0d exp %0d",
                  cyc, mem.text_addr, e_ta[sl]);
      end
      s = cyc - 2;
      if (s >= 0) begin
         if (e_fachk[s % 8] && last_rst < s) begin
            n_vec++;
            if (mem.font_addr !== 12'(e_fa[s % 8])) begin
               n_err++;
               $display("FAIL font_addr cyc %0d got %0d exp %0d",
                        cyc, mem.font_addr, e_fa[s % 8]);
            end
         end
      end
      s = cyc - 4;
      if (s >= 0) begin
         ep = (last_rst >= s) ? 1'b0 : e_pix[s % 8];
         es = (last_rst >= s) ? 3'b000 : e_sync[s % 8];
         n_vec++;
         if (pixel_on !== ep) begin
            n_err++;
            $display("FAIL pixel_on cyc %0d got %b exp %b",
                     cyc, pixel_on, ep);
         end
         n_vec++;
         if ({de_out, hs_out, vs_out} !== es) begin
            n_err++;
            $display("FAIL syncs cyc %0d got %b exp %b",
                     cyc, {de_out, hs_out, vs_out}, es);
         end
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic frame_edge(input logic sr, input logic cl);
      idle(5);
      step(0, 0, 0, 0, 1, sr, cl, 0);
      step(0, 0, 0, 0, 1, 0, 0, 0);
      idle(5);
   endtask

   task automatic test_reset();
      step(100, 40, 1, 1, 1, 0, 0, 1);
      step(200, 80, 1, 1, 0, 0, 0, 1);
      n_vec++;
      if ({pixel_on, de_out, hs_out, vs_out} !== 4'b0000 ||
          mem.text_addr !== 12'd0 || mem.font_addr !== 12'd0) begin
         n_err++;
         $display("FAIL reset_outputs got %b/%0d/%0d exp 0",
                  {pixel_on, de_out, hs_out, vs_out},
                  mem.text_addr, mem.font_addr);
      end
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1, 1, 0, 0, 0, 0);
         n_vec++;
         if (de_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flush_de cyc %0d got %b exp 0", i, de_out);
         end
      end
      step(0, 0, 1, 1, 0, 0, 0, 0);
      n_vec++;
      if (de_out !== 1'b1) begin
         n_err++;
         $display("FAIL reset_release_de got %b exp 1", de_out);
      end
      idle(6);
   endtask

   task automatic test_basic();
      for (int i = 0; i < 4096; i++) begin
         tmem[i] = 8'h41; fontm[i] = 9'h100;
      end
      step(0, 0, 1, 0, 0, 0, 0, 0);
      n_vec++;
      if (mem.text_addr !== 12'd0) begin
         n_err++;
         $display("FAIL basic_text_addr got %0d exp 0", mem.text_addr);
      end
      step(1, 0, 1, 0, 0, 0, 0, 0);
      idle(1);
      n_vec++;
      if (mem.font_addr !== 12'd1040) begin
         n_err++;
         $display("FAIL basic_font_addr got %0d exp 1040", mem.font_addr);
      end
      idle(2);
      n_vec++;
      if (pixel_on !== 1'b1) begin
         n_err++;
         $display("FAIL basic_pix_xo0 got %b exp 1", pixel_on);
      end
      idle(1);
      n_vec++;
      if (pixel_on !== 1'b0) begin
         n_err++;
         $display("FAIL basic_pix_xo1 got %b exp 0", pixel_on);
      end
      idle(6);
   endtask

   task automatic test_out_of_area();
      step(630, 0, 1, 0, 0, 0, 0, 0);
      n_vec++;
      if (mem.text_addr !== 12'd0) begin
         n_err++;
         $display("FAIL ooa_text_addr got %0d exp 0", mem.text_addr);
      end
      idle(4);
      n_vec++;
      if (pixel_on !== 1'b0 || de_out !== 1'b1) begin
         n_err++;
         $display("FAIL ooa_pix_de got %b%b exp 01", pixel_on, de_out);
      end
      step(0, 480, 1, 0, 0, 0, 0, 0);
      idle(6);
   endtask

   task automatic test_scroll();
      step(0, 0, 0, 0, 0, 0, 1, 0);
      step(50, 20, 1, 0, 0, 1, 0, 0);
      step(59, 20, 1, 0, 0, 1, 0, 0);
      frame_edge(0, 0);
      step(0, 0, 1, 0, 0, 0, 0, 0);
      n_vec++;
      if (mem.text_addr !== 12'd70) begin
         n_err++;
         $display("FAIL scroll_one got %0d exp 70", mem.text_addr);
      end
      frame_edge(0, 0);
      step(0, 0, 1, 0, 0, 0, 0, 0);
      n_vec++;
      if (mem.text_addr !== 12'd70) begin
         n_err++;
         $display("FAIL scroll_collapse got %0d exp 70", mem.text_addr);
      end
      for (int i = 0; i < NR - 1; i++) begin
         step(9, 16, 1, 0, 0, 1, 0, 0);
         frame_edge(0, 0);
      end
      step(0, 0, 1, 0, 0, 0, 0, 0);
      n_vec++;
      if (mem.text_addr !== 12'd0) begin
         n_err++;
         $display("FAIL scroll_wrap got %0d exp 0", mem.text_addr);
      end
      frame_edge(1, 0);
      step(0, 0, 1, 0, 0, 0, 0, 0);
      n_vec++;
      if (mem.text_addr !== 12'd0) begin
         n_err++;
         $display("FAIL scroll_same_fs got %0d exp 0", mem.text_addr);
      end
      frame_edge(0, 0);
      step(0, 0, 1, 0, 0, 0, 0, 0);
      n_vec++;
      if (mem.text_addr !== 12'd70) begin
         n_err++;
         $display("FAIL scroll_deferred got %0d exp 70", mem.text_addr);
      end
      idle(6);
   endtask

   task automatic test_clear_scroll();
      step(0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 0, 0, 1, 0, 0);
         frame_edge(0, 0);
      end
      step(0, 0, 1, 0, 0, 0, 0, 0);
      n_vec++;
      if (mem.text_addr !== 12'd350) begin
         n_err++;
         $display("FAIL clear_pre got %0d exp 350", mem.text_addr);
      end
      step(0, 0, 0, 0, 0, 1, 1, 0);
      frame_edge(0, 0);
      step(0, 0, 1, 0, 0, 0, 0, 0);
      n_vec++;
      if (mem.text_addr !== 12'd0) begin
         n_err++;
         $display("FAIL clear_wins got %0d exp 0", mem.text_addr);
      end
      step(0, 0, 0, 0, 0, 1, 0, 0);
      frame_edge(0, 1);
      frame_edge(0, 0);
      step(0, 0, 1, 0, 0, 0, 0, 0);
      n_vec++;
      if (mem.text_addr !== 12'd0) begin
         n_err++;
         $display("FAIL clear_at_fs got %0d exp 0", mem.text_addr);
      end
      idle(6);
   endtask

   task automatic test_prompt();
      int ta;
      for (int i = 0; i < 4096; i++) begin
         tmem[i] = 8'($urandom); fontm[i] = 9'($urandom);
      end
      prompt_en = 1'b1; cursor_row = 8'd3; cursor_en = 1'b0;
      step(18, 53, 1, 0, 0, 0, 0, 0);
      idle(2);
      n_vec++;
      if (mem.font_addr !== 12'd1845) begin
         n_err++;
         $display("FAIL prompt_col2 got %0d exp 1845", mem.font_addr);
      end
      step(81, 53, 1, 0, 0, 0, 0, 0);
      idle(2);
      ta = ((3 + m_base) % NR) * NC + 9;
      n_vec++;
      if (mem.font_addr !== 12'((int'(tmem[ta]) * CH + 5) % 4096)) begin
         n_err++;
         $display("FAIL prompt_col9 got %0d exp %0d", mem.font_addr,
                  (int'(tmem[ta]) * CH + 5) % 4096);
      end
      for (int i = 0; i < 40; i++)
         step($urandom_range(0, 120), $urandom_range(40, 70), 1,
              1'($urandom), 0, 0, 0, 0);
      idle(6);
      prompt_en = 1'b0;
   endtask

   task automatic test_blink();
      for (int i = 0; i < 4096; i++) fontm[i] = 9'h000;
      step(0, 0, 0, 0, 0, 0, 0, 1);
      idle(6);
      cursor_en = 1'b1; cursor_col = 8'd4; cursor_row = 8'd2;
      for (int f = 0; f < 8; f++) begin
         step(36, 32, 1, 1, 0, 0, 0, 0);
         idle(4);
         n_vec++;
         if (pixel_on !== ((f / 2) % 2 == 0)) begin
            n_err++;
            $display("FAIL blink_frame %0d got %b exp %b", f, pixel_on,
                     ((f / 2) % 2 == 0));
         end
         step(45, 32, 1, 0, 0, 0, 0, 0);
         idle(4);
         n_vec++;
         if (pixel_on !== 1'b0) begin
            n_err++;
            $display("FAIL blink_neighbour %0d got %b exp 0", f, pixel_on);
         end
         for (int x = 0; x < CW; x++)
            step(36 + x, 32 + $urandom_range(0, 15), 1, 1'($urandom), 0,
                 0, 0, 0);
         frame_edge(0, 0);
      end
      cursor_en = 1'b0;
   endtask

   task automatic test_random();
      int h, v;
      for (int i = 0; i < 4096; i++) fontm[i] = 9'($urandom);
      for (int f = 0; f < 40; f++) begin
         prompt_en  = 1'($urandom);
         cursor_en  = ($urandom_range(0, 3) != 0);
         cursor_col = 8'($urandom_range(0, 75));
         cursor_row = 8'($urandom_range(0, 33));
         for (int i = 0; i < 64; i++) tmem[$urandom_range(0, 4095)] = 8'($urandom);
         for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               h = int'(cursor_col) * CW + $urandom_range(0, CW - 1);
               v = int'(cursor_row) * CH + $urandom_range(0, CH - 1);
               if (h > 1023) h = 1023;
               if (v > 1023) v = 1023;
            end else begin
               h = $urandom_range(0, 1) ? $urandom_range(0, 629) :
                                          $urandom_range(0, 1023);
               v = $urandom_range(0, 1) ? $urandom_range(0, 479) :
                                          $urandom_range(0, 1023);
            end
            step(h, v, ($urandom_range(0, 9) != 0), 1'($urandom), 0,
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 60) == 0),
                 (f == 20 && (i == 30 || i == 31)));
         end
         frame_edge(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_out_of_area();
      test_scroll();
      test_clear_scroll();
      test_prompt();
      test_blink();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vga_text_pipeline.md
Name: vga_text_pipeline

Overview:
- Parametrised text-mode VGA render pipeline; successor to the fixed-geometry character storage block.
- Converts scan coordinates to a character cell and fetches the character from external text RAM. Substitutes the shell prompt on the cursor row, then fetches the glyph row from the external font ROM and emits one pixel per clock.
- Adds features the previous block lacked: hardware scroll (ring-buffer row base), blinking cursor, and fixed-latency alignment of sync/DE.
- Sits between the VGA timing generator and the colour output mux.

Parameters:
- CHAR_W, 9, glyph width in pixels (1..16)
- CHAR_H, 16, glyph height in lines (1..32)
- COLS, 70, text columns
- ROWS, 30, text rows; COLS*ROWS <= 4096
- PROMPT_LEN, 9, prompt characters shown at columns 0..PROMPT_LEN-1 of cursor row
- BLINK_FRAMES, 30, frames per cursor blink half-period (>=1)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- h_addr  in  10  horizontal pixel coordinate
- v_addr  in  10  vertical pixel coordinate
- de_in  in  1  display enable from timing generator
- hs_in  in  1  hsync from timing generator
- vs_in  in  1  vsync from timing generator (active-high pulse)
- text_addr  out  12  text RAM address
- text_data  in  8  text RAM read data, valid 1 cycle after text_addr
- font_addr  out  12  font ROM address
- font_row  in  CHAR_W  glyph row, valid 1 cycle after font_addr; MSB = leftmost pixel
- cursor_col  in  8  cursor column (logical screen)
- cursor_row  in  8  cursor row (logical screen)
- cursor_en  in  1  show cursor
- prompt_en  in  1  overlay prompt on cursor row
- scroll_req  in  1  one-cycle pulse: scroll up one row
- clear_scroll  in  1  one-cycle pulse: scroll base to 0
- pixel_on  out  1  foreground pixel
- de_out, hs_out, vs_out  out  1 each  syncs delayed to align with pixel_on

Behaviour:
- Reset (rst=1 at edge): all outputs 0, scroll_base=0, scroll_pending=0, frame_cnt=0, blink_phase=1, all pipeline stage registers 0.
- Latency: inputs sampled at edge k; pixel_on/de_out/hs_out/vs_out updated at edge k+4.
- Edge k: register col=h_addr/CHAR_W, xo=h_addr%CHAR_W, row=v_addr/CHAR_H, yo=v_addr%CHAR_H, and in_area=(col<COLS && row<ROWS && de_in). Results must be exact for 0..1023.
- Also at edge k: text_addr = ((row+scroll_base) mod ROWS)*COLS + col. When !in_area, text_addr=0.
- Edge k+2: select ch = PROMPT[col] if prompt_en && row==cursor_row && col<PROMPT_LEN, else text_data. Register font_addr = ch*CHAR_H + yo, truncated to 12 bits.
- Edge k+4: pixel_on = in_area & (font_row[CHAR_W-1-xo] XOR cursor_hit).
- cursor_hit = cursor_en && blink_phase && col==cursor_col && row==cursor_row.
- Cursor coordinates ≥ COLS/ROWS: never hit.
- Prompt string "SSshell$ " (0x53 0x53 0x73 0x68 0x65 0x6C 0x6C 0x24 0x20); PROMPT_LEN > 9 pads with 0x20.
- frame_start = rising edge of vs_in, detected with a 1-cycle registered vs_in.
- Scroll: scroll_req sets scroll_pending. At frame_start with pending set, scroll_base = (scroll_base+1) mod ROWS and pending clears. Multiple requests within one frame collapse to one scroll.
- clear_scroll sets scroll_base=0 and clears pending immediately. It wins over a simultaneous scroll_req and over a simultaneous frame_start.
- Scroll_req in the same cycle as frame_start is applied at the next frame_start.
- Blink: frame_cnt increments on frame_start. At BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
- Reset mid-frame: pipeline flushes; outputs stay 0 for 4 cycles after rst deasserts, then track inputs.

Decomposition:
- Package vga_text_pkg: PROMPT byte constant array, PROMPT_MAX=16, address width constants (TEXT_AW=12, FONT_AW=12), LATENCY=4.
- Sub-module vga_cell_locator: h_addr/v_addr to col, xo, row, yo, in_area, registered, parametrised by CHAR_W, CHAR_H, COLS, ROWS.

Test Plan:
- Reset then h=0,v=0,de=1 with text RAM model all 0x41 and font ROM model returning row 9'h100 → text_addr=0 at edge 1, font_addr=0x41*16=1040, pixel_on=1 at edge 4 for xo=0, 0 for xo=1.
- h=630 (col 70) → in_area=0, text_addr=0, pixel_on=0 with de_out=1.
- scroll_req pulse mid-frame, then vs_in rise → scroll_base 0→1; next frame row 0 gives text_addr=70. At ROWS-1, one more scroll wraps scroll_base to 0.
- scroll_req and clear_scroll in the same cycle with base=5 → base=0, pending=0, no scroll at the next frame_start.
- prompt_en=1, cursor_row=3, v in row 3, col 2 → font_addr=0x73*16+yo regardless of text_data. Col 9 uses text_data.
- cursor_en=1 at cell (4,2), BLINK_FRAMES=2 → cell pixels inverted for 2 frames, normal for 2 frames, repeating. hs/vs/de_out equal inputs delayed exactly 4 cycles.
